// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor.
// Consumes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first,
// and publishes a registered result with carry, signed-overflow and zero flags.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1 (IDLE). Operands and subtract are sampled on that edge only. busy
// stays high while digits are processed; done pulses for exactly one cycle,
// and Result/flags are valid during that pulse and held until the next done.
// start seen outside IDLE is dropped, never queued.
module serial_adder_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             subtract,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic             Cout,
   output logic             Overflow,
   output logic             Zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] sa;       // A, consumed from the bottom
   logic [WIDTH-1:0] sb;       // B or ~B, consumed from the bottom
   logic [WIDTH-1:0] acc;      // sum digits, filled from the top
   logic             c;        // inter-digit carry
   logic [CW-1:0]    cnt;      // digits processed so far

   logic [DIGIT:0]   dsum;
   logic             cin_msb;
   logic [WIDTH-1:0] dig_ext;
   logic [WIDTH-1:0] acc_nx;
   logic             last;

   // Digit adder, carry into the digit's top bit, and next result shift value.
   always_comb begin
      dsum    = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
      // Sum bit = a ^ b ^ carry-in, so the carry into the top bit is recovered here.
      cin_msb = dsum[DIGIT-1] ^ sa[DIGIT-1] ^ sb[DIGIT-1];
      dig_ext = WIDTH'(dsum[DIGIT-1:0]);
      acc_nx  = (acc >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
      last    = (cnt == CW'(N - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic and status outputs decoded from the state.
   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand shifting, digit accumulation and final result/flag capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa       <= '0;
         sb       <= '0;
         acc      <= '0;
         c        <= 1'b0;
         cnt      <= '0;
         Result   <= '0;
         Cout     <= 1'b0;
         Overflow <= 1'b0;
         Zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa  <= A;
                  // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
                  sb  <= B ^ {WIDTH{subtract}};
                  c   <= subtract;
                  cnt <= '0;
                  acc <= '0;
               end
            end
            RUN: begin
               sa  <= sa >> DIGIT;
               sb  <= sb >> DIGIT;
               acc <= acc_nx;
               c   <= dsum[DIGIT];
               cnt <= cnt + CW'(1);
               if (last) begin
                  Result   <= acc_nx;
                  Cout     <= dsum[DIGIT];
                  Overflow <= cin_msb ^ dsum[DIGIT];
                  Zero     <= (acc_nx == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Bench for serial_adder_subtractor: directed table at 16/4, hand-written
// corner sequences, and an exhaustive WIDTH=4 sweep over DIGIT = 1, 2, 4.
module tb_serial_adder_subtractor;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- 16-bit, DIGIT=4 instance ----------------
   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        sub16 = 1'b0;
   logic        ready16, busy16, done16;
   logic [15:0] res16;
   logic        cout16, ovf16, zero16;

   serial_adder_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16),
      .subtract(sub16), .ready(ready16), .busy(busy16), .done(done16),
      .Result(res16), .Cout(cout16), .Overflow(ovf16), .Zero(zero16)
   );

   // ---------------- 4-bit sweep instances ----------------
   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       sub4 = 1'b0;
   logic       rdy4 [3];
   logic       busy4 [3];
   logic       done4 [3];
   logic [3:0] res4 [3];
   logic       c4 [3];
   logic       v4 [3];
   logic       z4 [3];

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int DG = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      serial_adder_subtractor #(.WIDTH(4), .DIGIT(DG)) dut4 (
         .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
         .subtract(sub4), .ready(rdy4[g]), .busy(busy4[g]), .done(done4[g]),
         .Result(res4[g]), .Cout(c4[g]), .Overflow(v4[g]), .Zero(z4[g])
      );
   end

   // ---------------- scoreboard ----------------
   logic [18:0] exp_q[$];   // {cout, ovf, zero, result[15:0]}
   logic [6:0]  exp4_q[$];  // {cout, ovf, zero, result[3:0]}
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] prev_r = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Word-level reference for the 4-bit sweep.
   function automatic logic [6:0] model4(input logic [3:0] ma, input logic [3:0] mb, input logic ms);
      logic [3:0] r;
      logic       co, ov;
      r  = ms ? (ma - mb) : (ma + mb);
      co = ms ? (ma >= mb) : ((5'(ma) + 5'(mb)) > 5'd15);
      ov = ms ? ((ma[3] != mb[3]) && (r[3] != ma[3]))
              : ((ma[3] == mb[3]) && (r[3] != ma[3]));
      return {co, ov, (r == 4'd0), r};
   endfunction

   // ---------------- driver: one 16-bit operation ----------------
   task automatic run_op16(input string nm, input logic [15:0] ta, input logic [15:0] tbv,
                           input logic ts, input logic [18:0] te);
      int  k;
      logic got;
      exp_q.push_back(te);
      @(negedge clk);
      a16 = ta; b16 = tbv; sub16 = ts; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      check({nm, "_accept"}, {30'd0, ready16, busy16}, 32'd1);
      k = 0;
      got = 1'b0;
      while (k < 10 && !got) begin
         @(negedge clk);
         k++;
         if (done16) got = 1'b1;
         else check({nm, "_hold"}, {16'd0, res16}, {16'd0, prev_r});
      end
      check({nm, "_done_seen"}, {31'd0, got}, 32'd1);
      check({nm, "_latency"}, k, 32'd4);
      if (got && exp_q.size() > 0)
         check(nm, {13'd0, cout16, ovf16, zero16, res16}, {13'd0, exp_q.pop_front()});
      else if (exp_q.size() > 0)
         void'(exp_q.pop_front());
      @(negedge clk);
      check({nm, "_pulse"}, {30'd0, done16, ready16}, 32'd1);
      prev_r = te[15:0];
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [18:0] exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int ndone;
      int seen [3];
      int nlat [3];
      logic [15:0] prev;

      nlat[0] = 4; nlat[1] = 2; nlat[2] = 1;

      // {cout, ovf, zero, result}
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, {3'b000, 16'h5555}};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, {3'b101, 16'h0000}};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, {3'b010, 16'h8000}};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, {3'b000, 16'hFFFE}};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, {3'b110, 16'h7FFF}};
      vecs[5] = '{16'h1234, 16'h1234, 1'b1, {3'b101, 16'h0000}};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, {3'b111, 16'h0000}};
      vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b1, {3'b010, 16'h8000}};

      // Reset state.
      #1;
      check("reset_outputs", {9'd0, ready16, busy16, done16, cout16, ovf16, zero16, res16},
            {9'd0, 3'b100, 3'b000, 16'h0000});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 8; i++)
         run_op16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp);

      // start pulsed mid-RUN with operands changed: one done, original operands.
      prev = prev_r;
      exp_q.push_back({3'b100, 16'h00FF});
      @(negedge clk);
      a16 = 16'h0100; b16 = 16'h0001; sub16 = 1'b1; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done16) begin
            ndone++;
            if (exp_q.size() > 0)
               check("midrun_result", {13'd0, cout16, ovf16, zero16, res16}, {13'd0, exp_q.pop_front()});
         end else if (ndone == 0) begin
            check("midrun_hold", {16'd0, res16}, {16'd0, prev});
         end
         if (k == 1) begin
            start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b0;
         end
         if (k == 2) start16 = 1'b0;
      end
      check("midrun_done_count", ndone, 32'd1);
      prev_r = 16'h00FF;

      // start held high: accepted every N+2 cycles.
      exp_q.push_back({3'b000, 16'h1010});
      exp_q.push_back({3'b000, 16'h1010});
      @(negedge clk);
      a16 = 16'h0F0F; b16 = 16'h0101; sub16 = 1'b0; start16 = 1'b1;
      ndone = 0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (done16) begin
            check("cont_done_time", k, (ndone == 0) ? 32'd4 : 32'd10);
            if (exp_q.size() > 0)
               check("cont_result", {13'd0, cout16, ovf16, zero16, res16}, {13'd0, exp_q.pop_front()});
            ndone++;
         end
      end
      start16 = 1'b0;
      check("cont_done_count", ndone, 32'd2);
      prev_r = 16'h1010;

      // Reset during RUN: immediate clear, no done, clean restart.
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h4321; sub16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {9'd0, ready16, busy16, done16, cout16, ovf16, zero16, res16},
            {9'd0, 3'b100, 3'b000, 16'h0000});
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done16) ndone++;
      end
      check("abort_no_done", ndone, 32'd0);
      rst_n = 1'b1;
      prev_r = 16'h0000;
      run_op16("after_abort", 16'h0001, 16'h0001, 1'b0, {3'b000, 16'h0002});

      // Exhaustive 4-bit sweep, three digit sizes in lockstep.
      for (int op = 0; op < 512; op++) begin
         logic [8:0] ov;
         ov = op[8:0];
         exp4_q.push_back(model4(ov[3:0], ov[7:4], ov[8]));
         @(negedge clk);
         a4 = ov[3:0]; b4 = ov[7:4]; sub4 = ov[8]; start4 = 1'b1;
         @(negedge clk);
         start4 = 1'b0;
         check("sweep_busy", {29'd0, busy4[0], busy4[1], busy4[2]}, 32'd7);
         for (int i = 0; i < 3; i++) seen[i] = 0;
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               if (done4[i]) begin
                  seen[i]++;
                  check($sformatf("sweep_n%0d_latency", nlat[i]), k, nlat[i]);
                  check($sformatf("sweep_n%0d_op%0d", nlat[i], op),
                        {25'd0, c4[i], v4[i], z4[i], res4[i]}, {25'd0, exp4_q[0]});
               end
            end
         end
         for (int i = 0; i < 3; i++)
            check($sformatf("sweep_n%0d_done_count", nlat[i]), seen[i], 32'd1);
         check("sweep_ready", {29'd0, rdy4[0], rdy4[1], rdy4[2]}, 32'd7);
         void'(exp4_q.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
